// File: rtl/lcd_pkg.sv
// Shared LCD package: default timing, reader state encoding, busy-flag index.
package lcd_pkg;

    localparam int unsigned LCD_PULSE_E_DLY = 12;
    localparam int unsigned LCD_SETUP_DLY   = 2;
    localparam int unsigned LCD_BF_BIT      = 7;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_E_HI0,
        ST_E_LO0,
        ST_E_HI1,
        ST_E_LO1,
        ST_CHECK
    } lcd_state_t;

    // Bits needed to hold max_val (at least 1).
    function automatic int unsigned cnt_width(input int unsigned max_val);
        int unsigned w;
        w = 1;
        for (int unsigned i = 1; i < 32; i++) begin
            if ((max_val >> i) != 0) w = i + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/lcd_phase_timer.sv
// Loadable down-counter; done is high for exactly one cycle, load_val+1
// cycles after the load edge.
module lcd_phase_timer #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic             done
);

    logic [WIDTH-1:0] cnt;
    logic             active;

    assign done = active && (cnt == '0);

    // Count down after a load; disarm once done has been signalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt    <= '0;
            active <= 1'b0;
        end else if (load) begin
            cnt    <= load_val;
            active <= 1'b1;
        end else if (done) begin
            active <= 1'b0;
        end else if (active) begin
            cnt <= cnt - 1'b1;
        end
    end

endmodule

// File: rtl/lcd_reader.sv
// LCD 4-bit bus reader: single byte reads and busy-flag polling.
module lcd_reader
    import lcd_pkg::*;
#(
    parameter int unsigned PULSE_E_DLY = LCD_PULSE_E_DLY,
    parameter int unsigned SETUP_DLY   = LCD_SETUP_DLY,
    parameter int unsigned MAX_POLLS   = 1000
) (
    input  logic       clk,
    input  logic       rst,
    output logic       lcd_e,
    output logic       lcd_rw,
    output logic       lcd_rs,
    output logic       lcd_d_oe,
    input  logic [3:0] lcd_d_in,
    input  logic       if_read,
    input  logic       if_poll,
    input  logic       if_rs,
    output logic       if_ready,
    output logic       if_valid,
    output logic [7:0] if_data,
    output logic       if_timeout
);

    localparam int unsigned TMAX = (PULSE_E_DLY > SETUP_DLY) ? PULSE_E_DLY : SETUP_DLY;
    localparam int unsigned TW   = cnt_width(TMAX);
    localparam int unsigned PW   = cnt_width(MAX_POLLS);

    localparam logic [TW-1:0] PULSE_LOAD = TW'(PULSE_E_DLY);
    localparam logic [TW-1:0] SETUP_LOAD = TW'(SETUP_DLY);
    localparam logic [PW-1:0] POLL_LAST  = PW'(MAX_POLLS - 1);

    lcd_state_t    state;
    logic          is_poll;
    logic [PW-1:0] poll_cnt;
    logic          accept;
    logic          repoll;
    logic          timer_load;
    logic [TW-1:0] timer_val;
    logic          timer_done;

    assign lcd_d_oe = ~lcd_rw;
    assign accept   = if_ready && (if_read || if_poll);
    assign repoll   = (state == ST_CHECK) && is_poll && if_data[LCD_BF_BIT]
                      && (poll_cnt != POLL_LAST);

    lcd_phase_timer #(.WIDTH(TW)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (timer_load),
        .load_val (timer_val),
        .done     (timer_done)
    );

    // Reload the phase timer on every edge that enters a timed state.
    always_comb begin
        timer_load = 1'b0;
        timer_val  = PULSE_LOAD;
        case (state)
            ST_IDLE: begin
                timer_load = accept;
                timer_val  = SETUP_LOAD;
            end
            ST_SETUP, ST_E_HI0, ST_E_LO0, ST_E_HI1: timer_load = timer_done;
            ST_CHECK: begin
                timer_load = repoll;
                timer_val  = SETUP_LOAD;
            end
            default: timer_load = 1'b0;
        endcase
    end

    // Read sequencer with registered bus and handshake outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            is_poll    <= 1'b0;
            poll_cnt   <= '0;
            lcd_e      <= 1'b0;
            lcd_rw     <= 1'b0;
            lcd_rs     <= 1'b0;
            if_ready   <= 1'b1;
            if_valid   <= 1'b0;
            if_data    <= '0;
            if_timeout <= 1'b0;
        end else begin
            if_valid <= 1'b0;
            case (state)
                ST_IDLE: if (accept) begin
                    is_poll    <= if_poll;
                    lcd_rs     <= if_poll ? 1'b0 : if_rs;
                    lcd_rw     <= 1'b1;
                    poll_cnt   <= '0;
                    if_ready   <= 1'b0;
                    if_timeout <= 1'b0;
                    state      <= ST_SETUP;
                end
                ST_SETUP: if (timer_done) begin
                    lcd_e <= 1'b1;
                    state <= ST_E_HI0;
                end
                ST_E_HI0: if (timer_done) begin
                    if_data[7:4] <= lcd_d_in;
                    lcd_e        <= 1'b0;
                    state        <= ST_E_LO0;
                end
                ST_E_LO0: if (timer_done) begin
                    lcd_e <= 1'b1;
                    state <= ST_E_HI1;
                end
                ST_E_HI1: if (timer_done) begin
                    if_data[3:0] <= lcd_d_in;
                    lcd_e        <= 1'b0;
                    state        <= ST_E_LO1;
                end
                ST_E_LO1: if (timer_done) begin
                    state <= ST_CHECK;
                end
                ST_CHECK: begin
                    if (is_poll && if_data[LCD_BF_BIT]) poll_cnt <= poll_cnt + 1'b1;
                    if (repoll) begin
                        state <= ST_SETUP;
                    end else begin
                        if_timeout <= is_poll && if_data[LCD_BF_BIT];
                        lcd_rw     <= 1'b0;
                        if_valid   <= 1'b1;
                        if_ready   <= 1'b1;
                        state      <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_reader.sv
// Self-checking bench for lcd_reader with a behavioural LCD read model.
module tb_lcd_reader;

    localparam int LAT_PER_READ = 56;   // 3 + 4*13 + 1 with default timing

    logic       clk = 1'b0;
    logic       rst;
    logic       lcd_e, lcd_rw, lcd_rs, lcd_d_oe;
    logic [3:0] lcd_d_in = 4'h0;
    logic       if_read, if_poll, if_rs;
    logic       if_ready, if_valid, if_timeout;
    logic [7:0] if_data;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int e_cnt  = 0;
    int base   = 0;
    logic [4:0][7:0] cur_resp;

    typedef struct {
        logic            rd;
        logic            pl;
        logic            rs;
        logic [4:0][7:0] resp;   // resp[0] answers the first read
        logic [7:0]      exp_data;
        logic            exp_to;
        logic            exp_rs;
        int              n_reads;
    } vec_t;

    lcd_reader #(.MAX_POLLS(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .lcd_e      (lcd_e),
        .lcd_rw     (lcd_rw),
        .lcd_rs     (lcd_rs),
        .lcd_d_oe   (lcd_d_oe),
        .lcd_d_in   (lcd_d_in),
        .if_read    (if_read),
        .if_poll    (if_poll),
        .if_rs      (if_rs),
        .if_ready   (if_ready),
        .if_valid   (if_valid),
        .if_data    (if_data),
        .if_timeout (if_timeout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // LCD model: each E rise presents the next nibble, upper first.
    always @(posedge lcd_e) begin
        int k, idx;
        logic [7:0] b;
        k   = e_cnt - base;
        idx = (k / 2 > 4) ? 4 : k / 2;
        b   = cur_resp[idx];
        lcd_d_in = (k % 2 == 0) ? b[7:4] : b[3:0];
        e_cnt = e_cnt + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic rd, input logic pl, input logic rs,
                                input logic [4:0][7:0] resp, input logic [7:0] d,
                                input logic to, input logic ers, input int n);
        vec_t v;
        v.rd = rd; v.pl = pl; v.rs = rs; v.resp = resp;
        v.exp_data = d; v.exp_to = to; v.exp_rs = ers; v.n_reads = n;
        return v;
    endfunction

    task automatic run_vec(input vec_t v, input string tag, input bit busy_req);
        int acc, lat, rs_bad, oe_bad, start_e;
        bit got, rdy;
        rdy = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (if_ready) begin rdy = 1; break; end
        end
        chk({tag, ".ready_wait"}, rdy, 1);
        cur_resp = v.resp;
        base     = e_cnt;
        if_read  = v.rd;
        if_poll  = v.pl;
        if_rs    = v.rs;
        @(posedge clk); #1;
        acc = cyc;
        chk({tag, ".acc_ready"}, if_ready, 0);
        chk({tag, ".acc_rw"}, lcd_rw, 1);
        chk({tag, ".acc_rs"}, lcd_rs, v.exp_rs);
        chk({tag, ".acc_timeout"}, if_timeout, 0);
        @(negedge clk);
        if_read = 0; if_poll = 0; if_rs = 0;
        if (busy_req) begin
            repeat (4) @(negedge clk);
            if_read = 1; if_poll = 1; if_rs = ~v.rs;
            @(negedge clk);
            if_read = 0; if_poll = 0; if_rs = 0;
        end
        got = 0; rs_bad = 0; oe_bad = 0;
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #1;
            if (lcd_d_oe !== ~lcd_rw) oe_bad++;
            if (if_valid) begin got = 1; break; end
            if (lcd_rs !== v.exp_rs) rs_bad++;
        end
        lat = cyc - acc;
        chk({tag, ".valid_seen"}, got, 1);
        chk({tag, ".latency"}, lat, LAT_PER_READ * v.n_reads);
        chk({tag, ".data"}, if_data, v.exp_data);
        chk({tag, ".timeout"}, if_timeout, v.exp_to);
        chk({tag, ".e_pulses"}, e_cnt - base, 2 * v.n_reads);
        chk({tag, ".done_ready"}, if_ready, 1);
        chk({tag, ".done_rw"}, lcd_rw, 0);
        chk({tag, ".rs_stable_bad"}, rs_bad, 0);
        chk({tag, ".oe_bad"}, oe_bad, 0);
        @(posedge clk); #1;
        chk({tag, ".valid_pulse"}, if_valid, 0);
        chk({tag, ".data_hold"}, if_data, v.exp_data);
        chk({tag, ".timeout_hold"}, if_timeout, v.exp_to);
        if (busy_req) begin
            start_e = e_cnt;
            repeat (60) @(posedge clk);
            #1;
            chk({tag, ".busy_ignored_e"}, e_cnt - start_e, 0);
            chk({tag, ".busy_ignored_ready"}, if_ready, 1);
        end
    endtask

    vec_t tbl[8];
    vec_t v41;

    initial begin
        int nvalid;
        bit reached;
        rst = 1; if_read = 0; if_poll = 0; if_rs = 0;
        cur_resp = '0;

        tbl[0] = mk(1, 0, 1, {8'h41, 8'h41, 8'h41, 8'h41, 8'h41}, 8'h41, 0, 1, 1);
        tbl[1] = mk(1, 0, 0, {8'h7A, 8'h7A, 8'h7A, 8'h7A, 8'h7A}, 8'h7A, 0, 0, 1);
        tbl[2] = mk(0, 1, 1, {8'h3C, 8'h3C, 8'h3C, 8'h3C, 8'h3C}, 8'h3C, 0, 0, 1);
        tbl[3] = mk(0, 1, 0, {8'h05, 8'h05, 8'h80, 8'h80, 8'h80}, 8'h05, 0, 0, 4);
        tbl[4] = mk(0, 1, 0, {8'h80, 8'h80, 8'h80, 8'h80, 8'h80}, 8'h80, 1, 0, 4);
        tbl[5] = mk(1, 1, 1, {8'h2C, 8'h2C, 8'h2C, 8'h2C, 8'h2C}, 8'h2C, 0, 0, 1);
        tbl[6] = mk(0, 1, 0, {8'h7F, 8'h7F, 8'h7F, 8'h7F, 8'hFF}, 8'h7F, 0, 0, 2);
        tbl[7] = mk(1, 0, 1, {8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF}, 8'hFF, 0, 1, 1);
        v41 = tbl[0];

        repeat (3) @(posedge clk);
        @(negedge clk); rst = 0;
        @(posedge clk); #1;
        chk("rst.lcd_e", lcd_e, 0);
        chk("rst.lcd_rw", lcd_rw, 0);
        chk("rst.lcd_rs", lcd_rs, 0);
        chk("rst.lcd_d_oe", lcd_d_oe, 1);
        chk("rst.if_ready", if_ready, 1);
        chk("rst.if_valid", if_valid, 0);
        chk("rst.if_data", if_data, 0);
        chk("rst.if_timeout", if_timeout, 0);

        for (int i = 0; i < 8; i++) run_vec(tbl[i], $sformatf("vec%0d", i), 0);

        // Requests raised while busy must not start a second transaction.
        run_vec(v41, "busy", 1);

        // Reset during the second E-high phase aborts without if_valid.
        @(negedge clk);
        cur_resp = v41.resp; base = e_cnt;
        if_read = 1; if_rs = 1;
        @(negedge clk);
        if_read = 0; if_rs = 0;
        reached = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (e_cnt - base >= 2) begin reached = 1; break; end
        end
        chk("abort.reach_e_hi1", reached, 1);
        repeat (3) @(negedge clk);
        chk("abort.pre_e", lcd_e, 1);
        rst = 1;
        @(posedge clk); #1;
        chk("abort.lcd_e", lcd_e, 0);
        chk("abort.lcd_rw", lcd_rw, 0);
        chk("abort.if_ready", if_ready, 1);
        chk("abort.if_valid", if_valid, 0);
        @(negedge clk); rst = 0;
        nvalid = 0;
        for (int i = 0; i < 80; i++) begin
            @(posedge clk); #1;
            if (if_valid) nvalid++;
        end
        chk("abort.no_valid", nvalid, 0);
        run_vec(v41, "after_abort", 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/lcd_reader.md
LCD_READER -- requirements
Module: lcd_reader

Interface
REQ-001 Parameter PULSE_E_DLY, default 12: E high and E low phase length is PULSE_E_DLY+1 clk cycles.
REQ-002 Parameter SETUP_DLY, default 2: RS/RW setup before the first E rise is SETUP_DLY+1 cycles.
REQ-003 Parameter MAX_POLLS, default 1000: maximum busy-flag reads per poll request.
REQ-004 clk  in  1  single system clock; all logic on its rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 lcd_e  out  1  LCD enable strobe.
REQ-007 lcd_rw  out  1  1 while a read transaction owns the bus, else 0.
REQ-008 lcd_rs  out  1  latched register select: 0 = busy flag/address, 1 = data RAM.
REQ-009 lcd_d_oe  out  1  FPGA data driver enable; equals ~lcd_rw.
REQ-010 lcd_d_in  in  4  LCD data nibble from the pad.
REQ-011 if_read  in  1  request a single 8-bit read.
REQ-012 if_poll  in  1  request busy-flag polling until BF=0.
REQ-013 if_rs  in  1  register select for if_read.
REQ-014 if_ready  out  1  block idle; accepts a request.
REQ-015 if_valid  out  1  one-cycle pulse; if_data/if_timeout valid.
REQ-016 if_data  out  8  assembled byte {upper nibble, lower nibble}.
REQ-017 if_timeout  out  1  poll ended on MAX_POLLS with BF still 1.

Function
REQ-018 States: IDLE, SETUP, E_HI0, E_LO0, E_HI1, E_LO1, CHECK.
REQ-019 Accept on a clk edge with if_ready=1 and (if_read|if_poll); if_ready drops the next cycle; requests while if_ready=0 are ignored.
REQ-020 if_poll and if_read both high: poll wins, RS forced 0.
REQ-021 At accept: latch RS (if_rs for read, 0 for poll), set lcd_rw=1, clear poll counter, enter SETUP.
REQ-022 SETUP, SETUP_DLY+1 cycles -> E_HI0 with lcd_e=1.
REQ-023 E_HI0, PULSE_E_DLY+1 cycles; on its last cycle, sample lcd_d_in into if_data[7:4], drop lcd_e -> E_LO0.
REQ-024 E_LO0, PULSE_E_DLY+1 cycles -> E_HI1 with lcd_e=1.
REQ-025 E_HI1 as E_HI0, sampling if_data[3:0] -> E_LO1; E_LO1 as E_LO0 -> CHECK.
REQ-026 CHECK, single read: lcd_rw=0, if_valid=1 for one cycle, if_ready=1, -> IDLE.
REQ-027 CHECK, poll with if_data[7]=0: complete as REQ-026 with if_timeout=0.
REQ-028 CHECK, poll with BF=1: increment counter; if count reaches MAX_POLLS, complete with if_timeout=1; else -> SETUP, lcd_rw held 1.
REQ-029 Latency, single read with defaults: if_valid high 3+4*13+1 = 56 cycles after the accept edge; general form SETUP_DLY+1+4*(PULSE_E_DLY+1)+1.
REQ-030 if_data and if_timeout hold until the next accept; if_timeout clears on accept.
REQ-031 lcd_rs is stable from accept until lcd_rw returns to 0.

Reset
REQ-032 rst forces IDLE, lcd_e=0, lcd_rw=0, lcd_rs=0, if_ready=1, if_valid=0, if_data=0, if_timeout=0, counters 0.
REQ-033 rst mid-transaction drops lcd_e and lcd_rw on the same edge; no if_valid is produced.
REQ-034 No power-up wait; the companion LCD write block owns initialisation.

Structure
REQ-035 Shared LCD package holds PULSE_E_DLY, SETUP_DLY, state encoding and BF bit index (7).
REQ-036 One sub-module, lcd_phase_timer: a loadable counter with a done pulse, reused by every timed state.

Verification
REQ-037 if_read, if_rs=1, LCD model returns 0x4 then 0x1 -> if_data=0x41, if_valid at cycle 56, lcd_rs=1 throughout.
REQ-038 if_poll, model BF=1 for 3 reads then 0x05 -> 4 E-pairs, if_data=0x05, if_timeout=0.
REQ-039 if_poll with MAX_POLLS=4, BF stuck 1 (0x80) -> exactly 4 reads, if_timeout=1, if_data=0x80.
REQ-040 rst asserted during E_HI1 -> lcd_e=0, lcd_rw=0 next edge, if_ready=1, no if_valid; the next if_read completes normally.
REQ-041 if_read and if_poll together, if_rs=1 -> lcd_rs=0, poll behaviour; request during busy ignored.
